// File: rtl/hit_display_pkg.sv
// Shared display-stage constants and marker state encoding.
// Used by the hit-marker controller and other display-stage blocks.
package hit_display_pkg;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
  // Must stay >= sprite half-extent (HEIGHT/RADIUS).
  localparam int MARGIN_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLINK = 2'd2
  } state_t;

endpackage

// File: rtl/hit_marker_ctrl_if.sv
// Hit-marker controller bus: timing/hit inputs and marker outputs.
// master drives hits and vsync; slave is the controller.
interface hit_marker_ctrl_if;

  logic        vsync;
  logic        hit_valid;
  logic [10:0] hit_x;
  logic [9:0]  hit_y;
  logic [10:0] x;
  logic [9:0]  y;
  logic        visible;
  logic [7:0]  hit_count;

  modport master (
    output vsync, hit_valid, hit_x, hit_y,
    input  x, y, visible, hit_count
  );

  modport slave (
    input  vsync, hit_valid, hit_x, hit_y,
    output x, y, visible, hit_count
  );

endinterface

// File: rtl/hit_marker_ctrl_frame_tick_gen.sv
// Registered rising-edge detector for vsync.
// Emits a one-cycle frame tick one cycle after the vsync rise.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vsync_i,
  output logic tick_o
);

  logic vs_q;
  logic tick_q;

  // vsync history and registered edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vsync_i;
      tick_q <= vsync_i & ~vs_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/hit_marker_ctrl.sv
// Frame-synchronous hit-marker controller: clamp, commit, hold, blink.
// Optional HIT_MARKER_SMOOTH_EN: retrigger commits average old/new position.
module hit_marker_ctrl
  import hit_display_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int MARGIN       = MARGIN_DEF,
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_PERIOD = 4
) (
  input logic             clk,
  input logic             reset,
  hit_marker_ctrl_if.slave bus
);

  localparam int FLW = $clog2(HOLD_FRAMES + 1);
  localparam int BCW = $clog2(BLINK_PERIOD + 1);

  localparam logic [10:0] X_LO = 11'(MARGIN);
  localparam logic [10:0] X_HI = 11'(H_ACTIVE - 1 - MARGIN);
  localparam logic [9:0]  Y_LO = 10'(MARGIN);
  localparam logic [9:0]  Y_HI = 10'(V_ACTIVE - 1 - MARGIN);

  logic           frame_tick;
  logic           commit;
  state_t         state_q, state_d;
  logic [10:0]    x_q, x_d, px_q, px_d, cx;
  logic [9:0]     y_q, y_d, py_q, py_d, cy;
  logic           vis_q, vis_d;
  logic           pend_q, pend_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [FLW-1:0] fl_q, fl_d;
  logic [BCW-1:0] bc_q, bc_d;
`ifdef HIT_MARKER_SMOOTH_EN
  logic [11:0]    sx;
  logic [10:0]    sy;
`endif

  frame_tick_gen u_tick (
    .clk     (clk),
    .reset   (reset),
    .vsync_i (bus.vsync),
    .tick_o  (frame_tick)
  );

  // Clamp raw hit coordinates into the displayable window
  always_comb begin
    cx = bus.hit_x;
    cy = bus.hit_y;
    if (bus.hit_x < X_LO)      cx = X_LO;
    else if (bus.hit_x > X_HI) cx = X_HI;
    if (bus.hit_y < Y_LO)      cy = Y_LO;
    else if (bus.hit_y > Y_HI) cy = Y_HI;
  end

  assign commit = frame_tick & pend_q;

  // Capture, commit and hold/blink next-state logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    pend_d  = pend_q;
    px_d    = px_q;
    py_d    = py_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    bc_d    = bc_q;
`ifdef HIT_MARKER_SMOOTH_EN
    sx      = 12'(x_q) + 12'(px_q);
    sy      = 11'(y_q) + 11'(py_q);
`endif

    if (bus.hit_valid) begin
      pend_d = 1'b1;
      px_d   = cx;
      py_d   = cy;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end else if (commit) begin
      pend_d = 1'b0;
    end

    if (commit) begin
`ifdef HIT_MARKER_SMOOTH_EN
      if (state_q != IDLE) begin
        x_d = sx[11:1];
        y_d = sy[10:1];
      end else begin
        x_d = px_q;
        y_d = py_q;
      end
`else
      x_d = px_q;
      y_d = py_q;
`endif
      fl_d    = FLW'(HOLD_FRAMES);
      bc_d    = '0;
      state_d = SHOW;
      vis_d   = 1'b1;
    end else if (frame_tick) begin
      unique case (state_q)
        IDLE: vis_d = 1'b0;
        SHOW: begin
          if (fl_q != '0) fl_d = fl_q - FLW'(1);
          if (fl_d == FLW'(BLINK_FRAMES)) begin
            state_d = BLINK;
            vis_d   = 1'b1;
            bc_d    = '0;
          end
        end
        BLINK: begin
          if (fl_q != '0) fl_d = fl_q - FLW'(1);
          if (fl_d == '0) begin
            state_d = IDLE;
            vis_d   = 1'b0;
          end else if (bc_q == BCW'(BLINK_PERIOD - 1)) begin
            bc_d  = '0;
            vis_d = ~vis_q;
          end else begin
            bc_d = bc_q + BCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          vis_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vis_q   <= 1'b0;
      pend_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      pend_q  <= pend_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      bc_q    <= bc_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.visible   = vis_q;
  assign bus.hit_count = cnt_q;

endmodule

// File: tb/tb_hit_marker_ctrl.sv
// Directed bench for hit_marker_ctrl.
// Expected marker positions come from a small clamp/commit model.
module tb_hit_marker_ctrl;

  logic clk = 1'b0;
  logic reset;

  hit_marker_ctrl_if bus ();

  hit_marker_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int nhits = 0;
  int ex = 0;
  int ey = 0;
  bit on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cl(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int vis_exp(input int k);
    if (k < 90) return 1;
    if (k >= 120) return 0;
    return (((k - 90) / 4) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic expect_commit(input int px, input int py);
    int cx;
    int cy;
    cx = cl(px, 16, 1007);
    cy = cl(py, 16, 751);
`ifdef HIT_MARKER_SMOOTH_EN
    if (on) begin
      ex = (ex + cx) >> 1;
      ey = (ey + cy) >> 1;
    end else begin
      ex = cx;
      ey = cy;
    end
`else
    ex = cx;
    ey = cy;
`endif
    on = 1'b1;
  endtask

  task automatic check_xy(input string tag);
    chk({tag, ".x"}, 32'(bus.x), ex);
    chk({tag, ".y"}, 32'(bus.y), ey);
  endtask

  task automatic hit(input int hx, input int hy);
    bus.hit_valid = 1'b1;
    bus.hit_x     = 11'(hx);
    bus.hit_y     = 10'(hy);
    @(negedge clk);
    bus.hit_valid = 1'b0;
    nhits++;
  endtask

  task automatic frame();
    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.vsync     = 1'b0;
    bus.hit_valid = 1'b0;
    bus.hit_x     = '0;
    bus.hit_y     = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      frame();
      chk("idle.vis", 32'(bus.visible), 0);
      check_xy("idle");
      chk("idle.cnt", 32'(bus.hit_count), 0);
    end

    hit(500, 300);
    expect_commit(500, 300);
    chk("pre.vis", 32'(bus.visible), 0);
    bus.vsync = 1'b1;
    @(negedge clk);
    chk("tick.vis", 32'(bus.visible), 0);
    bus.vsync = 1'b0;
    @(negedge clk);
    chk("commit.vis", 32'(bus.visible), 1);
    check_xy("commit");
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 120; k++) begin
      frame();
      chk($sformatf("hold.k%0d", k), 32'(bus.visible), vis_exp(k));
    end
    on = 1'b0;
    check_xy("idle_keep");

    hit(3, 760);
    frame();
    expect_commit(3, 760);
    check_xy("clampA");
    hit(1020, 0);
    frame();
    expect_commit(1020, 0);
    check_xy("clampB");

    hit(100, 100);
    hit(200, 200);
    frame();
    expect_commit(200, 200);
    check_xy("newest");

    bus.vsync = 1'b1;
    @(negedge clk);
    bus.vsync     = 1'b0;
    bus.hit_valid = 1'b1;
    bus.hit_x     = 11'd300;
    bus.hit_y     = 10'd400;
    @(negedge clk);
    bus.hit_valid = 1'b0;
    nhits++;
    check_xy("coinc.hold");
    repeat (3) @(negedge clk);
    frame();
    expect_commit(300, 400);
    check_xy("coinc.late");

    repeat (95) frame();
    chk("blink.k95", 32'(bus.visible), 0);
    hit(700, 500);
    frame();
    expect_commit(700, 500);
    chk("retrig.vis", 32'(bus.visible), 1);
    check_xy("retrig");
    repeat (93) frame();
    chk("retrig.k93", 32'(bus.visible), 1);
    frame();
    chk("retrig.k94", 32'(bus.visible), 0);

    chk("cnt", 32'(bus.hit_count), nhits);
    repeat (300) hit(600, 400);
    chk("cnt.sat", 32'(bus.hit_count), 255);
    frame();
    expect_commit(600, 400);
    chk("pre_rst.vis", 32'(bus.visible), 1);
    check_xy("pre_rst");

    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst.vis", 32'(bus.visible), 0);
    chk("rst.x", 32'(bus.x), 0);
    chk("rst.y", 32'(bus.y), 0);
    chk("rst.cnt", 32'(bus.hit_count), 0);
    on = 1'b0;
    ex = 0;
    ey = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    hit(50, 60);
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk);
    expect_commit(50, 60);
    check_xy("rst.first");
    hit(70, 80);
    repeat (5) @(negedge clk);
    check_xy("held");
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    frame();
    expect_commit(70, 80);
    check_xy("held.next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hit_marker_ctrl.md
Name: hit_marker_ctrl

Overview:
Frame-synchronous controller upstream of the hit-marker sprite generator. It accepts hit events (coordinates from the detection path), clamps them to the displayable area, and commits them only at frame start so the marker never tears mid-frame. It holds the marker for a fixed number of frames, blinks it near expiry, then hides it. Outputs are the marker x/y (directly driving the sprite's x/y inputs) and a visible flag, which the mixer ANDs with the sprite pixel.

Parameters:
H_ACTIVE, 1024, active pixels per line
V_ACTIVE, 768, active lines per frame
MARGIN, 16, minimum distance of marker centre from any screen edge (>= sprite half-extent)
HOLD_FRAMES, 120, total frames a committed hit is displayed (>= BLINK_FRAMES+1)
BLINK_FRAMES, 30, final frames of the hold during which the marker blinks
BLINK_PERIOD, 4, frames per blink half-cycle

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  vertical sync from the XVGA timing generator, level signal
hit_valid  in  1  single-cycle hit strobe
hit_x  in  11  hit column, raw
hit_y  in  10  hit row, raw
x  out  11  committed marker column
y  out  10  committed marker row
visible  out  1  marker enable for the current frame
hit_count  out  8  accepted hits, saturating

Behaviour:
- Reset (async, active-high): x=0, y=0, visible=0, hit_count=0, pending=0, frames_left=0, state IDLE, vsync history=0.
- frame_tick: registered rising-edge detect of vsync. It is a one-cycle pulse, 1 cycle after the vsync rise. A vsync held high gives exactly one tick.
- Capture: on hit_valid, the clamped coordinates are written to the pending register and pending is set to 1.
  - Clamp rule: cx = min(max(hit_x, MARGIN), H_ACTIVE-1-MARGIN); same for y with V_ACTIVE.
  - A newer hit overwrites an uncommitted pending hit (newest wins).
  - hit_count increments per hit_valid and saturates at 255.
- Commit: on frame_tick with pending=1:
  - x/y <= pending coordinates; frames_left <= HOLD_FRAMES; state <= SHOW; pending cleared.
  - Coordinates are stable for the whole frame; x/y only change on a frame_tick cycle.
- Simultaneous hit_valid and frame_tick: the previously pending hit (if any) commits. The new hit goes into pending and commits at the next tick. If nothing was pending, the new hit waits one frame.
- States (all transitions happen only on frame_tick):
  - IDLE: visible=0. Leaves on a commit.
  - SHOW: visible=1. frames_left decrements per tick. At frames_left==BLINK_FRAMES, go to BLINK with the blink phase reset to "on".
  - BLINK: frames_left decrements per tick. visible toggles every BLINK_PERIOD ticks, starting "on". At frames_left==0, go to IDLE.
  - A commit in SHOW or BLINK restarts SHOW with full HOLD_FRAMES (retrigger).
- visible is registered and updates in the same cycle as state. In IDLE, x/y retain their last values.
- Counter widths are sized by $clog2 of the parameters; there is no wrap anywhere (decrements stop at 0).
- Reset mid-frame: outputs clear immediately (async); the first commit follows the first full vsync rise after reset deassertion.

Optional Feature:
HIT_MARKER_SMOOTH_EN:
- Defined: a commit while in SHOW or BLINK writes x <= (x + px) >> 1 and y <= (y + py) >> 1. Use 12-/11-bit intermediate sums; the result is within the clamp range by construction. A commit from IDLE loads the coordinates directly.
- Undefined: every commit loads the coordinates directly.

Decomposition:
- Shared package (hit_display_pkg):
  - state encoding constants IDLE/SHOW/BLINK
  - H_ACTIVE/V_ACTIVE defaults
  - MARGIN, kept consistent with the sprite HEIGHT/RADIUS.
- One natural sub-module: frame_tick_gen (vsync edge detector with async reset), reusable by other display-stage blocks.
- Clamp logic stays inline.

Test Plan:
- Reset release, vsync toggling, no hits -> visible=0, x=0, y=0, hit_count=0 for 3 frames.
- hit (500,300) mid-frame -> x=500, y=300, visible=1 from the 2nd cycle after the next vsync rise; visible stays 1 for 90 ticks, blinks 4-on/4-off for 30 ticks, then returns to 0.
- hit (3,760) -> committed x=16, y=751. Hit (1020,0) -> x=1007, y=16.
- Two hits (100,100) then (200,200) in one frame -> only (200,200) is committed. hit_valid coincident with frame_tick -> that hit appears one frame later.
- Retrigger: a hit during BLINK -> back to SHOW, visible=1, full 120-frame hold. With HIT_MARKER_SMOOTH_EN, (100,100) then (200,300) -> x=150, y=200.
- 300 hits -> hit_count=255. Assert reset during SHOW -> visible=0, x=0 immediately, asynchronously.
